// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: sequences CPU accesses, serves the device page
// (KBSR/KBDR/DSR/DDR/MCR) from local registers and forwards the rest to memory.
module lc3_mem_ctrl #(
    parameter int          TIMEOUT   = 16,
    parameter logic [15:0] MCR_RESET = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_mio_en,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_r,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_r,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_char,
    output logic        kbd_ready,
    output logic        kbd_int,
    output logic        disp_valid,
    output logic [7:0]  disp_char,
    input  logic        disp_ack,
    output logic        run,
    output logic        bus_err
);
    localparam logic [15:0] A_KBSR = 16'hFE00;
    localparam logic [15:0] A_KBDR = 16'hFE02;
    localparam logic [15:0] A_DSR  = 16'hFE04;
    localparam logic [15:0] A_DDR  = 16'hFE06;
    localparam logic [15:0] A_MCR  = 16'hFFFE;
    localparam int          CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MEM_ISSUE, S_MEM_WAIT, S_DEV_ACC, S_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [15:0]   r_addr, r_wdata;
    logic          r_rw;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_cpu_rdata;
    logic          r_cpu_r;
    logic          r_mem_en, r_mem_rw;
    logic [15:0]   r_mem_addr, r_mem_wdata;
    logic          r_kb_full, r_kb_ie;
    logic [7:0]    r_kbdr;
    logic          r_dsr_ready;
    logic [7:0]    r_ddr;
    logic [15:0]   r_mcr;
    logic          r_bus_err;

    logic          w_req_dev, w_cnt_last, w_dev_acc, w_kbdr_rd;
    logic [15:0]   w_dev_rdata;

    assign w_req_dev  = (cpu_addr == A_KBSR) || (cpu_addr == A_KBDR) || (cpu_addr == A_DSR) ||
                        (cpu_addr == A_DDR)  || (cpu_addr == A_MCR);
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_dev_acc  = (r_state == S_DEV_ACC);
    assign w_kbdr_rd  = w_dev_acc && !r_rw && (r_addr == A_KBDR);

    always_comb begin
        w_dev_rdata = 16'h0000;
        case (r_addr)
            A_KBSR:  w_dev_rdata = {r_kb_full, r_kb_ie, 14'd0};
            A_KBDR:  w_dev_rdata = {8'h00, r_kbdr};
            A_DSR:   w_dev_rdata = {r_dsr_ready, 15'd0};
            A_MCR:   w_dev_rdata = r_mcr;
            default: w_dev_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (cpu_mio_en) w_state_next = w_req_dev ? S_DEV_ACC : S_MEM_ISSUE;
            S_MEM_ISSUE: w_state_next = S_MEM_WAIT;
            S_MEM_WAIT:  if (mem_r || w_cnt_last) w_state_next = S_DONE;
            S_DEV_ACC:   w_state_next = S_DONE;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rw        <= 1'b0;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_cpu_r     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_kb_full   <= 1'b0;
            r_kb_ie     <= 1'b0;
            r_kbdr      <= '0;
            r_dsr_ready <= 1'b1;
            r_ddr       <= '0;
            r_mcr       <= MCR_RESET;
            r_bus_err   <= 1'b0;
        end else begin
            r_cpu_r  <= 1'b0;
            r_mem_en <= 1'b0;
            case (r_state)
                S_IDLE: if (cpu_mio_en) begin
                    r_addr  <= cpu_addr;
                    r_rw    <= cpu_rw;
                    r_wdata <= cpu_wdata;
                    if (!w_req_dev) begin
                        r_mem_en    <= 1'b1;
                        r_mem_rw    <= cpu_rw;
                        r_mem_addr  <= cpu_addr;
                        r_mem_wdata <= cpu_wdata;
                    end
                end
                S_MEM_ISSUE: begin
                    r_mem_rw <= 1'b0;
                    r_cnt    <= '0;
                end
                S_MEM_WAIT: begin
                    // A ready arriving on the last allowed cycle still wins over the timeout.
                    if (mem_r) begin
                        if (!r_rw) r_cpu_rdata <= mem_rdata;
                        r_cpu_r <= 1'b1;
                        r_cnt   <= '0;
                    end else if (w_cnt_last) begin
                        r_cpu_rdata <= '0;
                        r_bus_err   <= 1'b1;
                        r_cpu_r     <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DEV_ACC: begin
                    r_cpu_r <= 1'b1;
                    if (!r_rw) r_cpu_rdata <= w_dev_rdata;
                    else begin
                        case (r_addr)
                            A_KBSR: r_kb_ie <= r_wdata[14];
                            A_DDR: if (r_dsr_ready) begin
                                r_ddr       <= r_wdata[7:0];
                                r_dsr_ready <= 1'b0;
                            end
                            A_MCR: begin
                                r_mcr     <= r_wdata;
                                r_bus_err <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase

            // DSR ready is clear only while a character is pending, so an ack cannot
            // collide with an accepted DDR write.
            if (disp_ack && !r_dsr_ready) r_dsr_ready <= 1'b1;

            if (kbd_valid && !r_kb_full) begin
                r_kb_full <= 1'b1;
                r_kbdr    <= kbd_char;
            end else if (w_kbdr_rd) begin
                r_kb_full <= 1'b0;
            end
        end
    end

    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_r      = r_cpu_r;
    assign mem_en     = r_mem_en;
    assign mem_rw     = r_mem_rw;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign kbd_ready  = !r_kb_full;
    assign kbd_int    = r_kb_full && r_kb_ie;
    assign disp_valid = !r_dsr_ready;
    assign disp_char  = r_ddr;
    assign run        = r_mcr[15];
    assign bus_err    = r_bus_err;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed plus randomized bench for lc3_mem_ctrl against a transaction-level
// model of memory, keyboard, display and MCR state.
module tb_lc3_mem_ctrl;
    localparam int          TIMEOUT   = 16;
    localparam logic [15:0] MCR_RESET = 16'h8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_mio_en, cpu_rw;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_r;
    logic        mem_en, mem_rw;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_r;
    logic        kbd_valid, kbd_ready, kbd_int;
    logic [7:0]  kbd_char, disp_char;
    logic        disp_valid, disp_ack, run, bus_err;

    lc3_mem_ctrl #(.TIMEOUT(TIMEOUT), .MCR_RESET(MCR_RESET)) dut (
        .clk(clk), .rst(rst),
        .cpu_mio_en(cpu_mio_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_r(mem_r),
        .kbd_valid(kbd_valid), .kbd_char(kbd_char), .kbd_ready(kbd_ready),
        .kbd_int(kbd_int), .disp_valid(disp_valid), .disp_char(disp_char),
        .disp_ack(disp_ack), .run(run), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model_mem follows the CPU's view; resp_mem is what the memory actually received.
    logic [15:0] model_mem [0:65535];
    logic [15:0] resp_mem  [0:65535];

    bit          kb_full, kb_ie, disp_busy, bus_err_m, last_known;
    logic [7:0]  kb_char, disp_ch;
    logic [15:0] mcr_m, last_rd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        kb_full = 0; kb_ie = 0; kb_char = 8'h00;
        disp_busy = 0; disp_ch = 8'h00;
        mcr_m = MCR_RESET; bus_err_m = 0;
        last_rd = 16'h0000; last_known = 1;
    endtask

    function automatic bit is_dev_addr(input logic [15:0] a);
        return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) ||
               (a == 16'hFE06) || (a == 16'hFFFE);
    endfunction

    function automatic logic [15:0] dev_read(input logic [15:0] a);
        case (a)
            16'hFE00: return {kb_full, kb_ie, 14'd0};
            16'hFE02: return {8'h00, kb_char};
            16'hFE04: return {!disp_busy, 15'd0};
            16'hFFFE: return mcr_m;
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic check_side();
        chk("kbd_ready",  16'(kbd_ready),  16'(!kb_full));
        chk("kbd_int",    16'(kbd_int),    16'(kb_full && kb_ie));
        chk("disp_valid", 16'(disp_valid), 16'(disp_busy));
        chk("disp_char",  16'(disp_char),  16'(disp_ch));
        chk("run",        16'(run),        16'(mcr_m[15]));
        chk("bus_err",    16'(bus_err),    16'(bus_err_m));
    endtask

    // One CPU access. dly = cycles after the first allowed ready slot; <0 = memory never answers.
    task automatic access(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                          input int dly, input bit kb_poke);
        bit          dev, tout, done, armed;
        int          j, n_en, rcnt, exp_lat;
        logic [15:0] exp_rd, raddr;
        dev     = is_dev_addr(addr);
        tout    = !dev && !(dly >= 0 && dly <= TIMEOUT - 1);
        exp_lat = dev ? 2 : (tout ? TIMEOUT + 2 : dly + 3);
        if (!rw) exp_rd = dev ? dev_read(addr) : (tout ? 16'h0000 : model_mem[addr]);
        else     exp_rd = tout ? 16'h0000 : last_rd;

        @(negedge clk);
        cpu_mio_en = 1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
        j = 0; n_en = 0; done = 0; armed = 0; rcnt = 0; raddr = 16'h0000;
        while (!done && j < 40) begin
            @(negedge clk);
            j++;
            mem_r = 0;
            mem_rdata = 16'($urandom);
            if (kb_poke) begin
                kbd_valid = (j == 1);
                kbd_char  = 8'h42;
            end
            if (mem_en === 1'b1) begin
                n_en++;
                chk("mem_addr", mem_addr, addr);
                chk("mem_rw", 16'(mem_rw), 16'(rw));
                if (rw) begin
                    chk("mem_wdata", mem_wdata, wd);
                    resp_mem[mem_addr] = mem_wdata;
                end
                raddr = mem_addr;
                if (dly >= 0) begin armed = 1; rcnt = dly; end
            end else if (armed) begin
                if (rcnt == 0) begin
                    mem_r = 1; mem_rdata = resp_mem[raddr]; armed = 0;
                end else rcnt--;
            end
            if (cpu_r === 1'b1) begin
                done = 1;
                cpu_mio_en = 0;
                chk("latency", 16'(j), 16'(exp_lat));
                if (!rw || (!dev && (tout || last_known))) chk("cpu_rdata", cpu_rdata, exp_rd);
            end
        end
        chk("cpu_r_seen", 16'(done), 16'd1);
        cpu_mio_en = 0; kbd_valid = 0; mem_r = 0;
        chk("mem_en_cycles", 16'(n_en), dev ? 16'd0 : 16'd1);
        @(negedge clk);
        chk("cpu_r_pulse", 16'(cpu_r), 16'd0);

        if (dev) begin
            if (rw) begin
                case (addr)
                    16'hFE00: kb_ie = wd[14];
                    16'hFE06: if (!disp_busy) begin disp_ch = wd[7:0]; disp_busy = 1; end
                    16'hFFFE: begin mcr_m = wd; bus_err_m = 0; end
                    default: ;
                endcase
                last_known = 0;
            end else begin
                last_rd = exp_rd; last_known = 1;
                if (addr == 16'hFE02) kb_full = 0;
            end
        end else begin
            if (rw) model_mem[addr] = wd;
            if (tout) begin bus_err_m = 1; last_rd = 16'h0000; last_known = 1; end
            else if (!rw) begin last_rd = exp_rd; last_known = 1; end
        end
        $display("access rw=%0d addr=%h wdata=%h dly=%0d rdata=%h", rw, addr, wd, dly, cpu_rdata);
        check_side();
    endtask

    task automatic kb_offer(input logic [7:0] c);
        @(negedge clk);
        kbd_valid = 1; kbd_char = c;
        @(negedge clk);
        kbd_valid = 0;
        if (!kb_full) begin kb_full = 1; kb_char = c; end
        $display("kbd offer %h", c);
        check_side();
    endtask

    task automatic dack();
        @(negedge clk);
        disp_ack = 1;
        @(negedge clk);
        disp_ack = 0;
        disp_busy = 0;
        $display("display ack");
        check_side();
    endtask

    logic [15:0] dev_list [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; cpu_mio_en = 0; cpu_rw = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_rdata = 0; mem_r = 0; kbd_valid = 0; kbd_char = 0; disp_ack = 0;
        for (int i = 0; i < 65536; i++) begin
            model_mem[i] = 16'($urandom);
            resp_mem[i]  = model_mem[i];
        end
        model_mem[16'h3000] = 16'h1234; resp_mem[16'h3000] = 16'h1234;
        dev_list = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'hFE08, 16'hFF00, 16'hFFFF};
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_cpu_r", 16'(cpu_r), 16'd0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
        chk("rst_mem_en", 16'(mem_en), 16'd0);
        chk("rst_mem_rw", 16'(mem_rw), 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        check_side();
        rst = 0;

        access(0, 16'h3000, 16'h0000, 0, 0);
        chk("read_x3000", cpu_rdata, 16'h1234);
        access(1, 16'h4000, 16'hBEEF, 0, 0);
        chk("write_keeps_rdata", cpu_rdata, 16'h1234);

        kb_offer(8'h41);
        access(0, 16'hFE00, 16'h0000, 0, 0);
        chk("kbsr_full", cpu_rdata, 16'h8000);
        access(0, 16'hFE02, 16'h0000, 0, 1);
        chk("kbdr_read", cpu_rdata, 16'h0041);
        access(0, 16'hFE02, 16'h0000, 0, 0);
        chk("kbdr_not_replaced", cpu_rdata, 16'h0041);

        access(1, 16'hFE06, 16'h0048, 0, 0);
        access(0, 16'hFE04, 16'h0000, 0, 0);
        chk("dsr_busy", cpu_rdata, 16'h0000);
        access(1, 16'hFE06, 16'h0049, 0, 0);
        chk("ddr_discard", 16'(disp_char), 16'h0048);
        dack();
        access(0, 16'hFE04, 16'h0000, 0, 0);
        chk("dsr_ready", cpu_rdata, 16'h8000);

        access(0, 16'h3000, 16'h0000, TIMEOUT - 1, 0);
        access(0, 16'h5000, 16'h0000, -1, 0);
        chk("timeout_berr", 16'(bus_err), 16'd1);
        access(1, 16'hFFFE, 16'h0000, 0, 0);
        chk("mcr_clear", 16'({run, bus_err}), 16'd0);

        // Reset in the middle of a memory wait, with keyboard and display state pending.
        kb_offer(8'h55);
        access(1, 16'hFE06, 16'h0061, 0, 0);
        @(negedge clk);
        cpu_mio_en = 1; cpu_rw = 0; cpu_addr = 16'h3001;
        repeat (4) @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_mem_en", 16'(mem_en), 16'd0);
        chk("mid_rst_cpu_r", 16'(cpu_r), 16'd0);
        chk("mid_rst_rdata", cpu_rdata, 16'h0000);
        model_reset();
        check_side();
        cpu_mio_en = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_cpu_r", 16'(cpu_r), 16'd0);
        end
        rst = 0;
        $display("mid-access reset applied");
        access(0, 16'h3001, 16'h0000, 1, 0);

        for (int n = 0; n < 200; n++) begin
            int          sel, d, ds;
            logic [15:0] a;
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                ds = $urandom_range(0, 9);
                d  = (ds < 6) ? ds % 4 : (ds == 6) ? TIMEOUT - 1 : (ds == 7) ? -1 : 0;
                a  = 16'h3000 + 16'($urandom_range(0, 15));
                access(1'($urandom_range(0, 1)), a, 16'($urandom), d, 0);
            end else if (sel < 8) begin
                a = dev_list[$urandom_range(0, 7)];
                access(1'($urandom_range(0, 1)), a, 16'($urandom), 0, 0);
            end else if (sel == 8) begin
                kb_offer(8'($urandom));
            end else begin
                dack();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Sits between the LC-3 datapath's memory interface (MIO_EN/R.W/MAR/MDR/R handshake) and the main 64K x 16 synchronous memory.
- Sequences every CPU access and decodes the address space. Accesses to the device page are served from internal registers: KBSR, KBDR, DSR, DDR and MCR. All other addresses are forwarded to memory as a one-cycle strobe.
- Drives the keyboard/display device handshakes and the machine-run flag, and bounds memory waits with a timeout.

Parameters:
- TIMEOUT, 16, max cycles in MEM_WAIT before forced completion (>=2).
- MCR_RESET, 16'h8000, reset value of the MCR; bit 15 = clock enable.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_mio_en  in  1  CPU access request, held until cpu_r seen
- cpu_rw  in  1  1=write, 0=read
- cpu_addr  in  16  access address (MAR)
- cpu_wdata  in  16  write data (MDR)
- cpu_rdata  out  16  read data, valid while cpu_r=1
- cpu_r  out  1  access complete, one-cycle pulse
- mem_en  out  1  memory strobe
- mem_rw  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_r  in  1  memory ready
- kbd_valid  in  1  keyboard offers a character
- kbd_char  in  8  keyboard character
- kbd_ready  out  1  = ~KBSR[15]; character accepted when kbd_valid & kbd_ready
- kbd_int  out  1  = KBSR[15] & KBSR[14]
- disp_valid  out  1  DDR character pending for display
- disp_char  out  8  = DDR[7:0]
- disp_ack  in  1  display consumed character
- run  out  1  = MCR[15]
- bus_err  out  1  sticky; set on memory timeout, cleared by a write to MCR

Behaviour:
- Reset values: state=IDLE, cpu_r=0, cpu_rdata=0, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0, KBSR=0, KBDR=0, DSR=16'h8000, DDR=0, MCR=MCR_RESET, disp_valid=0, bus_err=0, timeout counter=0.
- Address decode:
  - FE00 KBSR: bit 15 ready (read-only), bit 14 interrupt enable (read/write).
  - FE02 KBDR: read-only.
  - FE04 DSR: bit 15 ready (read-only).
  - FE06 DDR: write-only; reads return 0.
  - FFFE MCR: read/write, all 16 bits.
  - Other FExx/FFxx addresses go to memory.
- FSM (all outputs registered):
  - IDLE: on cpu_mio_en, latch addr/rw/wdata. Go to DEV_ACC for a device address, otherwise MEM_ISSUE.
  - MEM_ISSUE: mem_en=1 for exactly one cycle with the latched fields -> MEM_WAIT.
  - MEM_WAIT: mem_en=0 and the counter increments.
    - On mem_r=1: capture mem_rdata on reads (cpu_rdata unchanged on writes) -> DONE.
    - On counter==TIMEOUT-1 without mem_r: cpu_rdata=0, bus_err=1 -> DONE.
  - DEV_ACC: perform the register read or write and its side effects -> DONE.
  - DONE: cpu_r=1 for one cycle -> IDLE. A request still asserted is only sampled in the following IDLE cycle.
- Latency: request sampled at edge k gives cpu_r high during cycle k+3 for memory (nominal mem_r) and cycle k+2 for device registers. The minimum gap between accepted requests is one IDLE cycle.
- Keyboard:
  - On kbd_valid & ~KBSR[15]: KBDR={8'h00,kbd_char} and KBSR[15]=1.
  - A completed KBDR read clears KBSR[15]. This clear wins over a same-cycle kbd_valid; that character is not accepted because kbd_ready=0 that cycle.
- Display:
  - DDR write with DSR[15]=1: DDR=wdata, DSR[15]=0, disp_valid=1.
  - On disp_ack & disp_valid: disp_valid=0, DSR[15]=1.
  - DDR write with DSR[15]=0: discarded (DDR unchanged) but still completes with cpu_r.
  - disp_ack while disp_valid=0 is ignored.
- MCR:
  - A write updates all 16 bits and clears bus_err.
  - run=0 does not abort the access in flight; it still completes.
- rst mid-access: state returns to IDLE immediately, mem_en drops, no cpu_r is issued, and pending display/keyboard state is lost.

Test Plan:
- Memory read x3000 with mem_r one cycle after mem_en, mem_rdata=x1234 -> mem_en high exactly one cycle, cpu_rdata=x1234 with cpu_r in cycle k+3, then IDLE.
- Memory write x4000<=xBEEF -> mem_rw=1, mem_addr=x4000, mem_wdata=xBEEF for one cycle, cpu_r pulse, cpu_rdata unchanged.
- kbd_valid with char x41 -> KBSR=x8000, kbd_ready=0. Read FE02 -> x0041 and KBSR[15] cleared. A second char offered in the same cycle as the read completion is not accepted.
- Write FE06<=x0048 -> disp_valid=1, disp_char=x48, DSR reads x0000. A second write of x0049 is ignored. disp_ack -> DSR reads x8000, disp_valid=0.
- mem_r never asserted, TIMEOUT=16 -> cpu_r 16 cycles after MEM_WAIT entry, cpu_rdata=0, bus_err=1. Write FFFE<=x0000 -> bus_err=0, run=0.
- rst asserted during MEM_WAIT -> next cycle all outputs at reset values, no cpu_r. A new request after deassert completes normally.
